// File: rtl/divider_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        CALC = 2'b11,
        POST = 2'b10
    } div_state_t;

endpackage

// File: rtl/divider_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module divider_negate #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    // Pass through or negate depending on neg
    always_comb begin
        if (neg) begin
            y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/divider_param.sv
// Multi-cycle restoring divider, unsigned or two's-complement, one quotient bit per cycle.
module divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strt,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             idle,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit            SGN  = (SIGNED != 0);

    div_state_t       state_r, state_n;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   rem_r;
    logic [CW-1:0]    cnt_r;
    logic             q_neg_r, r_neg_r, dz_r, hold_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             div_by_zero_r, idle_r, done_r;

    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] diff_s;
    logic [WIDTH-1:0] neg_a_in_s, neg_b_in_s, neg_a_out_s, neg_b_out_s;
    logic             neg_a_en_s, neg_b_en_s;
    logic             zero_div_s;

    assign zero_div_s = (divisor == {WIDTH{1'b0}});

    // a_r holds the dividend magnitude shifting out MSB first while quotient bits shift in
    assign shift_s = {rem_r[WIDTH-1:0], a_r[WIDTH-1]};
    assign diff_s  = {1'b0, shift_s} - {2'b00, b_r};

    // Negators are shared: operand magnitudes in PRE, result sign correction in POST
    always_comb begin
        neg_a_in_s = a_r;
        neg_b_in_s = b_r;
        neg_a_en_s = 1'b0;
        neg_b_en_s = 1'b0;
        case (state_r)
            PRE: begin
                neg_a_en_s = SGN & a_r[WIDTH-1];
                neg_b_en_s = SGN & b_r[WIDTH-1];
            end
            POST: begin
                neg_a_en_s = q_neg_r;
                neg_b_in_s = rem_r[WIDTH-1:0];
                neg_b_en_s = r_neg_r;
            end
            default: begin
                neg_a_en_s = 1'b0;
                neg_b_en_s = 1'b0;
            end
        endcase
    end

    divider_negate #(.WIDTH(WIDTH)) u_neg_a (
        .a   (neg_a_in_s),
        .neg (neg_a_en_s),
        .y   (neg_a_out_s)
    );

    divider_negate #(.WIDTH(WIDTH)) u_neg_b (
        .a   (neg_b_in_s),
        .neg (neg_b_en_s),
        .y   (neg_b_out_s)
    );

    // Next-state logic; zero-divisor POST lingers one extra cycle (hold_r) to give a two-cycle latency
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (strt) begin
                    if (zero_div_s) begin
                        state_n = POST;
                    end else begin
                        state_n = PRE;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            PRE:  state_n = CALC;
            CALC: begin
                if (cnt_r == LAST) begin
                    state_n = POST;
                end else begin
                    state_n = CALC;
                end
            end
            POST: begin
                if (hold_r) begin
                    state_n = POST;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            rem_r         <= {(WIDTH+1){1'b0}};
            cnt_r         <= {CW{1'b0}};
            q_neg_r       <= 1'b0;
            r_neg_r       <= 1'b0;
            dz_r          <= 1'b0;
            hold_r        <= 1'b0;
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
            idle_r        <= 1'b1;
            done_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            idle_r <= (state_n == IDLE);
            case (state_r)
                IDLE: begin
                    if (strt) begin
                        a_r    <= dividend;
                        b_r    <= divisor;
                        dz_r   <= zero_div_s;
                        hold_r <= zero_div_s;
                    end
                end
                PRE: begin
                    a_r     <= neg_a_out_s;
                    b_r     <= neg_b_out_s;
                    q_neg_r <= neg_a_en_s ^ neg_b_en_s;
                    r_neg_r <= neg_a_en_s;
                    rem_r   <= {(WIDTH+1){1'b0}};
                    cnt_r   <= {CW{1'b0}};
                end
                CALC: begin
                    a_r   <= {a_r[WIDTH-2:0], ~diff_s[WIDTH+1]};
                    rem_r <= diff_s[WIDTH+1] ? shift_s : diff_s[WIDTH:0];
                    cnt_r <= cnt_r + CW'(1);
                end
                POST: begin
                    if (hold_r) begin
                        hold_r <= 1'b0;
                    end else begin
                        done_r        <= 1'b1;
                        div_by_zero_r <= dz_r;
                        if (dz_r) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= a_r;
                        end else begin
                            quotient_r  <= neg_a_out_s;
                            remainder_r <= neg_b_out_s;
                        end
                    end
                end
                default: begin
                    hold_r <= 1'b0;
                end
            endcase
        end
    end

    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;
    assign idle        = idle_r;
    assign done        = done_r;

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench for divider_param: one unsigned and one signed 8-bit instance.
module tb_divider_param;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       u_strt = 1'b0, s_strt = 1'b0;
    logic [7:0] u_a = 8'd0, u_b = 8'd0, s_a = 8'd0, s_b = 8'd0;
    logic [7:0] u_q, u_r, s_q, s_r;
    logic       u_dz, s_dz, u_idle, s_idle, u_done, s_done;

    exp_t       uq[$];
    exp_t       sq[$];
    logic [7:0] u_lq = 8'd0, u_lr = 8'd0, s_lq = 8'd0, s_lr = 8'd0;
    logic       u_ldz = 1'b0, s_ldz = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_param #(.WIDTH(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .strt(u_strt), .dividend(u_a), .divisor(u_b),
        .quotient(u_q), .remainder(u_r), .div_by_zero(u_dz), .idle(u_idle), .done(u_done)
    );

    divider_param #(.WIDTH(8), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .strt(s_strt), .dividend(s_a), .divisor(s_b),
        .quotient(s_q), .remainder(s_r), .div_by_zero(s_dz), .idle(s_idle), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sb;
        e.dz  = 1'b0;
        e.cyc = 0;
        if (b == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!sgn) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            sa  = int'($signed(a));
            sb  = int'($signed(b));
            e.q = 8'(sa / sb);
            e.r = 8'(sa % sb);
        end
        return e;
    endfunction

    task automatic wait_idle(input bit sgn);
        int n = 0;
        while (((sgn ? s_idle : u_idle) !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(sgn ? "s_idle_timeout" : "u_idle_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; strt is sampled at the next rising edge
    task automatic start_op(input bit sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        wait_idle(sgn);
        e     = model(sgn, a, b);
        e.cyc = cyc + 1 + ((b == 8'd0) ? 2 : 10);
        if (sgn) begin
            s_a = a; s_b = b; s_strt = 1'b1;
            sq.push_back(e);
        end else begin
            u_a = a; u_b = b; u_strt = 1'b1;
            uq.push_back(e);
        end
        @(negedge clk);
        u_strt = 1'b0;
        s_strt = 1'b0;
    endtask

    // Unsigned-instance monitor: scoreboard compare on done, hold check otherwise
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            u_lq = 8'd0; u_lr = 8'd0; u_ldz = 1'b0;
        end else if (u_done) begin
            if (uq.size() == 0) begin
                check("u_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = uq.pop_front();
                check("u_quotient", 32'(u_q), 32'(e.q));
                check("u_remainder", 32'(u_r), 32'(e.r));
                check("u_dz", 32'(u_dz), 32'(e.dz));
                check("u_latency", 32'(cyc), 32'(e.cyc));
            end
            u_lq = u_q; u_lr = u_r; u_ldz = u_dz;
        end else begin
            check("u_hold", {15'd0, u_ldz, u_lr, u_lq}, {15'd0, u_dz, u_r, u_q});
        end
    end

    // Signed-instance monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            s_lq = 8'd0; s_lr = 8'd0; s_ldz = 1'b0;
        end else if (s_done) begin
            if (sq.size() == 0) begin
                check("s_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sq.pop_front();
                check("s_quotient", 32'(s_q), 32'(e.q));
                check("s_remainder", 32'(s_r), 32'(e.r));
                check("s_dz", 32'(s_dz), 32'(e.dz));
                check("s_latency", 32'(cyc), 32'(e.cyc));
            end
            s_lq = s_q; s_lr = s_r; s_ldz = s_dz;
        end else begin
            check("s_hold", {15'd0, s_ldz, s_lr, s_lq}, {15'd0, s_dz, s_r, s_q});
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_u_out", {15'd0, u_dz, u_r, u_q}, 32'd0);
        check("rst_s_out", {15'd0, s_dz, s_r, s_q}, 32'd0);
        check("rst_flags", {28'd0, u_idle, s_idle, u_done, s_done}, {28'd0, 4'b1100});
        rst = 1'b0;
        @(negedge clk);

        start_op(1'b0, 8'd200, 8'd7);
        start_op(1'b1, 8'hF9, 8'h02);
        start_op(1'b1, 8'h07, 8'hFE);
        start_op(1'b0, 8'h5A, 8'h00);
        start_op(1'b1, 8'h5A, 8'h00);
        start_op(1'b1, 8'h80, 8'hFF);
        start_op(1'b1, 8'h81, 8'h80);

        // Mid-CALC strt must be ignored; following op is launched on the done cycle
        start_op(1'b0, 8'd100, 8'd9);
        repeat (3) @(negedge clk);
        u_a = 8'd50; u_b = 8'd3; u_strt = 1'b1;
        @(negedge clk);
        u_strt = 1'b0;
        u_a = 8'd0; u_b = 8'd0;
        wait_idle(1'b0);
        check("b2b_on_done", 32'(u_done), 32'd1);
        start_op(1'b0, 8'd77, 8'd5);

        for (int i = 0; i < 12; i++) begin
            start_op(1'b0, 8'($urandom), (i % 5 == 4) ? 8'd0 : 8'($urandom_range(1, 255)));
            start_op(1'b1, 8'($urandom), (i % 5 == 2) ? 8'd0 : 8'($urandom_range(1, 255)));
        end

        // Reset during CALC: outputs clear at once and the abandoned op never completes
        start_op(1'b0, 8'd200, 8'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out", {15'd0, u_dz, u_r, u_q}, 32'd0);
        check("midrst_flags", {30'd0, u_idle, u_done}, {30'd0, 2'b10});
        uq.delete();
        sq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        start_op(1'b0, 8'd255, 8'd16);

        n = 0;
        while ((uq.size() != 0 || sq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pending_results", 32'(uq.size() + sq.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
